xgmii_frame_gen: RTL

- Parametrised XGMII test-frame generator; next generation of the fixed 10-word idle/frame pattern source.
- Drives the 64-bit XGMII TX interface of the 10G PCS/PMA test path.
- Adds per-frame runtime length with any byte alignment of the terminate, a programmable inter-frame gap, selectable payload pattern, frame-count limit and graceful stop.

---
 rtl/xgmii_pkg.sv | 47 ++++
 rtl/xgmii_term_word.sv | 30 +++
 rtl/xgmii_frame_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII constants, payload-mode and FSM state types for the
// test-frame generator and its companion checker.
package xgmii_pkg;

    localparam logic [7:0]  XGMII_IDLE  = 8'h07;
    localparam logic [7:0]  XGMII_START = 8'hFB;
    localparam logic [7:0]  XGMII_TERM  = 8'hFD;
    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;

    localparam logic [63:0] IDLE_WORD   = {8{XGMII_IDLE}};
    localparam logic [7:0]  IDLE_CTRL   = 8'hFF;
    localparam logic [63:0] PRE_WORD    = {XGMII_START, {6{PREAMBLE}}, SFD};
    localparam logic [7:0]  PRE_CTRL    = 8'h80;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_FILL = 2'd1,
        MODE_SEED = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_TERM,
        ST_GAP
    } state_e;

    // Payload byte at offset k of a frame; the reserved mode falls back to incrementing.
    function automatic logic [7:0] pattern_byte(
        input mode_e      mode,
        input logic [7:0] fill,
        input logic [7:0] seed,
        input logic [7:0] k
    );
        logic [7:0] b;
        case (mode)
            MODE_FILL: b = fill;
            MODE_SEED: b = seed + k;
            default:   b = k;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/xgmii_term_word.sv
// Builds the terminate-bearing XGMII word: r payload lanes, FD at lane r,
// idle in the lanes after it. r = 0 yields the bare FD070707_07070707 word.
module xgmii_term_word
    import xgmii_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [2:0]  i_rem,
    output logic [63:0] o_txd,
    output logic [7:0]  o_txc
);

    // Per-lane select between payload, terminate and idle.
    always_comb begin
        o_txd = '0;
        o_txc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(i_rem)) begin
                o_txd[63-8*i -: 8] = i_data[63-8*i -: 8];
                o_txc[7-i]         = 1'b0;
            end else if (i == 32'(i_rem)) begin
                o_txd[63-8*i -: 8] = XGMII_TERM;
                o_txc[7-i]         = 1'b1;
            end else begin
                o_txd[63-8*i -: 8] = XGMII_IDLE;
                o_txc[7-i]         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII test-frame generator: preamble, patterned payload of runtime length,
// byte-aligned terminate and a programmable idle gap, repeated per run.
module xgmii_frame_gen
    import xgmii_pkg::*;
#(
    parameter int unsigned P_LEN_W   = 16,
    parameter int unsigned P_MIN_LEN = 46,   // must be >= 8: PRE always leads into DATA
    parameter int unsigned P_MAX_LEN = 1500,
    parameter int unsigned P_GAP_W   = 16,
    parameter int unsigned P_CNT_W   = 32
)(
    input  logic               i_xgmii_clk,
    input  logic               i_xgmii_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [P_LEN_W-1:0] i_len,
    input  logic [P_GAP_W-1:0] i_gap,
    input  logic [1:0]         i_mode,
    input  logic [7:0]         i_fill,
    input  logic [P_CNT_W-1:0] i_frame_num,
    output logic [63:0]        o_xgmii_txd,
    output logic [7:0]         o_xgmii_txc,
    output logic               o_busy,
    output logic [P_CNT_W-1:0] o_frame_cnt
);

    localparam logic [P_LEN_W-1:0] MIN_LEN = P_LEN_W'(P_MIN_LEN);
    localparam logic [P_LEN_W-1:0] MAX_LEN = P_LEN_W'(P_MAX_LEN);
    localparam logic [P_LEN_W-1:0] WORD_B  = P_LEN_W'(8);

    function automatic logic [P_LEN_W-1:0] clamp_len(input logic [P_LEN_W-1:0] l);
        if (l < MIN_LEN)      return MIN_LEN;
        else if (l > MAX_LEN) return MAX_LEN;
        else                  return l;
    endfunction

    state_e             state_q, state_d;
    logic [P_LEN_W-1:0] rem_q, rem_d;          // payload bytes not yet emitted
    logic [7:0]         idx_q, idx_d;          // low byte of the next payload offset
    logic [P_GAP_W-1:0] gap_len_q, gap_len_d;
    logic [P_GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    mode_e              mode_q, mode_d;
    logic [7:0]         fill_q, fill_d;
    logic [7:0]         seed_q, seed_d;
    logic [P_CNT_W-1:0] num_q, num_d;
    logic [P_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [P_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               stop_q, stop_d;
    logic               last_q, last_d;        // current gap is the final one of the run
    logic               busy_q, busy_d;
    logic [63:0]        txd_q, txd_d;
    logic [7:0]         txc_q, txc_d;
    logic               frame_start;

    logic [63:0]        pay_word;
    logic [63:0]        term_txd;
    logic [7:0]         term_txc;

    // Eight consecutive pattern bytes starting at the current payload offset.
    always_comb begin
        pay_word = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            pay_word[63-8*i -: 8] = pattern_byte(mode_q, fill_q, seed_q, idx_q + 8'(i));
        end
    end

    // In TERM rem_q < 8, so its low bits are the clamped length mod 8.
    xgmii_term_word u_term (
        .i_data (pay_word),
        .i_rem  (rem_q[2:0]),
        .o_txd  (term_txd),
        .o_txc  (term_txc)
    );

    // Next-state, next-word and counter updates; the word chosen here is driven next cycle.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        mode_d      = mode_q;
        fill_d      = fill_q;
        seed_d      = seed_q;
        num_d       = num_q;
        run_cnt_d   = run_cnt_q;
        frame_cnt_d = frame_cnt_q;
        stop_d      = stop_q;
        last_d      = last_q;
        txd_d       = IDLE_WORD;
        txc_d       = IDLE_CTRL;
        frame_start = 1'b0;

        if (state_q != ST_IDLE && i_stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_PRE;
                    num_d       = i_frame_num;
                    run_cnt_d   = '0;
                    stop_d      = i_stop;
                    last_d      = 1'b0;
                    frame_start = 1'b1;
                end
            end
            ST_PRE: begin
                txd_d   = PRE_WORD;
                txc_d   = PRE_CTRL;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                txd_d = pay_word;
                txc_d = '0;
                idx_d = idx_q + 8'd8;
                rem_d = rem_q - WORD_B;
                if (rem_d < WORD_B) begin
                    state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                txd_d       = term_txd;
                txc_d       = term_txc;
                frame_cnt_d = frame_cnt_q + P_CNT_W'(1);
                run_cnt_d   = run_cnt_q + P_CNT_W'(1);
                last_d      = stop_q || i_stop ||
                              ((num_q != '0) && (run_cnt_q + P_CNT_W'(1) == num_q));
                gap_cnt_d   = gap_len_q;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q <= P_GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    if (last_q) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        state_d     = ST_PRE;
                        frame_start = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - P_GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Per-frame settings are captured on every entry to PRE.
        if (frame_start) begin
            rem_d     = clamp_len(i_len);
            idx_d     = '0;
            gap_len_d = (i_gap == '0) ? P_GAP_W'(1) : i_gap;
            mode_d    = mode_e'(i_mode);
            fill_d    = i_fill;
            seed_d    = frame_cnt_q[7:0];
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_xgmii_clk or negedge i_xgmii_rst_n) begin
        if (!i_xgmii_rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            idx_q       <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            mode_q      <= MODE_INC;
            fill_q      <= '0;
            seed_q      <= '0;
            num_q       <= '0;
            run_cnt_q   <= '0;
            frame_cnt_q <= '0;
            stop_q      <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            txd_q       <= IDLE_WORD;
            txc_q       <= IDLE_CTRL;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
            seed_q      <= seed_d;
            num_q       <= num_d;
            run_cnt_q   <= run_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            stop_q      <= stop_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
        end
    end

    assign o_xgmii_txd = txd_q;
    assign o_xgmii_txc = txc_q;
    assign o_busy      = busy_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
